video_frame_buffer: RTL

- Parametrised character/pixel frame store for the HDMI path.
- Port A is a handshaked CPU read/write port. Port B is a read-only display port with fixed latency.
- Built-in engines perform clear-screen (fill) and scroll-up-one-row.
- While an engine runs it owns port A's physical RAM port; CPU access stalls and the display port is unaffected.

---
 rtl/video_frame_buffer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/video_frame_buffer.sv
// Character/pixel frame store for the HDMI path.
// Port A: handshaked CPU read/write port, shared with the fill/scroll engines.
// Port B: read-only display port with a fixed latency of B_LAT (1 or 2) cycles.
module video_frame_buffer #(
   parameter int WIDTH = 3,
   parameter int COLS  = 100,
   parameter int ROWS  = 75,
   parameter int B_LAT = 1,
   localparam int XW = $clog2(COLS),
   localparam int YW = $clog2(ROWS),
   localparam int N  = COLS * ROWS,
   localparam int AW = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_req,
   input  logic             a_we,
   input  logic [XW-1:0]    a_x,
   input  logic [YW-1:0]    a_y,
   input  logic [WIDTH-1:0] a_wdata,
   output logic             a_ready,
   output logic             a_rvalid,
   output logic [WIDTH-1:0] a_rdata,
   input  logic [XW-1:0]    b_x,
   input  logic [YW-1:0]    b_y,
   output logic [WIDTH-1:0] b_rdata,
   input  logic             fill_start,
   input  logic             scroll_start,
   input  logic [WIDTH-1:0] fill_value,
   output logic             busy,
   output logic             done,
   output logic             a_err
);

   typedef enum logic [2:0] {IDLE, FILL, SC_RD, SC_WR, SC_CLR, DONE} state_t;

   localparam logic [AW-1:0] COLS_A      = AW'(COLS);
   localparam logic [AW-1:0] K_LAST      = AW'(N - 1);
   localparam logic [AW-1:0] K_SHIFT_END = AW'(N - COLS - 1);
   // A single-row frame has nothing to move up; scroll only clears.
   localparam bit            HAS_SHIFT   = (ROWS > 1);

   logic [WIDTH-1:0] mem [N];

   state_t           state;
   logic [AW-1:0]    k;
   logic [WIDTH-1:0] fillv;
   logic [WIDTH-1:0] sc_data;

   logic             a_in_range;
   logic             b_in_range;
   logic             a_acc;
   logic [AW-1:0]    addr_a;
   logic [AW-1:0]    addr_b;

   logic             we;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;

   logic [WIDTH-1:0] b_q1;
   logic [WIDTH-1:0] b_q2;

   assign a_in_range = (int'(a_x) < COLS) && (int'(a_y) < ROWS);
   assign b_in_range = (int'(b_x) < COLS) && (int'(b_y) < ROWS);
   assign addr_a     = AW'(a_y) * COLS_A + AW'(a_x);
   assign addr_b     = AW'(b_y) * COLS_A + AW'(b_x);

   // The CPU only owns the RAM port while no engine is running.
   assign a_ready = (state == IDLE);
   assign a_acc   = a_req && a_ready;

   // Single write port: CPU in IDLE, otherwise the active engine.
   always_comb begin
      // NOTE: defaults first so every path assigns every output (no latch).
      we    = 1'b0;
      waddr = '0;
      wdata = '0;
      unique case (state)
         IDLE: begin
            if (a_acc && a_we && a_in_range) begin
               we    = 1'b1;
               waddr = addr_a;
               wdata = a_wdata;
            end
         end
         FILL, SC_CLR: begin
            we    = 1'b1;
            waddr = k;
            wdata = fillv;
         end
         SC_WR: begin
            we    = 1'b1;
            waddr = k;
            wdata = sc_data;
         end
         default: ;
      endcase
   end

   // Frame RAM write.
   // NOTE: RAM contents are deliberately not reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // CPU read path: read-before-write, out-of-range reads return 0.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state always uses non-blocking assignments.
      if (!rst_n) begin
         a_rvalid <= 1'b0;
         a_rdata  <= '0;
      end else if (a_acc && !a_we) begin
         a_rvalid <= 1'b1;
         a_rdata  <= a_in_range ? mem[addr_a] : '0;
      end else begin
         a_rvalid <= 1'b0;
      end
   end

   // Sticky error flag for accepted out-of-range CPU accesses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      a_err <= 1'b0;
      else if (a_acc && !a_in_range)   a_err <= 1'b1;
   end

   // Display read pipeline; the second stage is only selected when B_LAT is 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_q1 <= '0;
         b_q2 <= '0;
      end else begin
         b_q1 <= b_in_range ? mem[addr_b] : '0;
         b_q2 <= b_q1;
      end
   end

   assign b_rdata = (B_LAT == 2) ? b_q2 : b_q1;

   // Engine FSM: fill and scroll sequencing with registered busy/done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         k       <= '0;
         fillv   <= '0;
         sc_data <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (fill_start) begin
                  fillv <= fill_value;
                  k     <= '0;
                  busy  <= 1'b1;
                  state <= FILL;
               end else if (scroll_start) begin
                  fillv <= fill_value;
                  k     <= '0;
                  busy  <= 1'b1;
                  state <= HAS_SHIFT ? SC_RD : SC_CLR;
               end
            end
            FILL, SC_CLR: begin
               if (k == K_LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            SC_RD: begin
               sc_data <= mem[k + COLS_A];
               state   <= SC_WR;
            end
            SC_WR: begin
               k     <= k + 1'b1;
               state <= (k == K_SHIFT_END) ? SC_CLR : SC_RD;
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
